// File: rtl/audio_playback_sequencer_if.sv
// Avalon-MM read-master bundle between the playback sequencer and the
// on-board flash controller. The sequencer takes the master side.
interface audio_playback_sequencer_if #(
   parameter int ADDR_W = 23
);
   logic              flash_read;
   logic [ADDR_W-1:0] flash_address;
   logic              flash_waitrequest;
   logic [31:0]       flash_readdata;
   logic              flash_readdatavalid;

   modport master (
      output flash_read, flash_address,
      input  flash_waitrequest, flash_readdata, flash_readdatavalid
   );

   modport slave (
      input  flash_read, flash_address,
      output flash_waitrequest, flash_readdata, flash_readdatavalid
   );
endinterface

// File: rtl/audio_playback_sequencer.sv
// Audio playback sequencer: fetches 32-bit words from flash (two 16-bit
// samples each) and emits the high byte of one sample per sample_tick.
// Owns play / pause / direction / restart.
// Build option PLAYBACK_LOOP_EN: when defined the image loops endlessly and
// done stays 0; when undefined, reaching the end of the image pulses done,
// reloads the start address for the current direction and pauses.
module audio_playback_sequencer #(
   parameter int                ADDR_W     = 23,
   parameter logic [ADDR_W-1:0] END_ADDR   = 23'h7FFFF,
   parameter logic [ADDR_W-1:0] START_ADDR = 23'h0
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       sample_tick,
   input  logic                       play,
   input  logic                       pause,
   input  logic                       dir,
   input  logic                       restart,
   audio_playback_sequencer_if.master flash,
   output logic [7:0]                 audio_data,
   output logic                       audio_valid,
   output logic                       playing,
   output logic                       overrun,
   output logic                       done
);

   typedef enum logic [2:0] {
      S_PAUSED,
      S_FETCH,
      S_WAIT_DATA,
      S_SAMPLE0,
      S_SAMPLE1,
      S_ADVANCE
   } state_t;

   state_t            state_reg, state_next;
   logic [ADDR_W-1:0] addr_reg, addr_next;
   logic [31:0]       word_reg;
   logic              word_fwd_reg;
   logic              pause_pend_reg, pause_pend_next;
   logic              restart_pend_reg, restart_pend_next;
   logic              done_next;
   logic              load_word, emit, set_overrun, tick_ok, accept;
   logic [7:0]        emit_byte, first_sample, second_sample;
   logic [7:0]        sample_hi [2];
   logic [ADDR_W-1:0] restart_addr, step_addr;
   logic              unused_low_bytes;

   // Only the high byte of each 16-bit sample is played.
   genvar gi;
   for (gi = 0; gi < 2; gi++) begin : g_lane
      assign sample_hi[gi] = word_reg[16*gi+8 +: 8];
   end
   assign unused_low_bytes = ^{word_reg[23:16], word_reg[7:0]};

   // Word order is fixed by the direction captured when the word was fetched,
   // so a direction change only takes effect at the next address step.
   assign first_sample  = word_fwd_reg ? sample_hi[0] : sample_hi[1];
   assign second_sample = word_fwd_reg ? sample_hi[1] : sample_hi[0];

   // A tick coinciding with pause or restart is swallowed entirely.
   assign tick_ok      = sample_tick && !pause && !restart;
   assign accept       = (state_reg == S_FETCH) && !flash.flash_waitrequest;
   assign restart_addr = dir ? START_ADDR : END_ADDR;

   // Next word address with explicit wrap at both ends of the image.
   always_comb begin
      if (dir)
         step_addr = (addr_reg == END_ADDR) ? START_ADDR : addr_reg + ADDR_W'(1);
      else
         step_addr = (addr_reg == START_ADDR) ? END_ADDR : addr_reg - ADDR_W'(1);
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!reset_n)
         state_reg <= S_PAUSED;
      else
         state_reg <= state_next;
   end

   // Next-state and datapath control decode.
   always_comb begin
      state_next        = state_reg;
      addr_next         = addr_reg;
      pause_pend_next   = pause_pend_reg;
      restart_pend_next = restart_pend_reg;
      load_word         = 1'b0;
      emit              = 1'b0;
      emit_byte         = 8'h00;
      set_overrun       = 1'b0;
      done_next         = 1'b0;
      unique case (state_reg)
         S_PAUSED: begin
            if (restart) begin
               addr_next = restart_addr;
            end else if (play && !pause) begin
               state_next        = S_FETCH;
               pause_pend_next   = 1'b0;
               restart_pend_next = 1'b0;
            end
         end
         S_FETCH: begin
            // Address must stay stable until accepted, so commands are deferred.
            if (restart)    restart_pend_next = 1'b1;
            else if (pause) pause_pend_next   = 1'b1;
            if (tick_ok)    set_overrun       = 1'b1;
            if (!flash.flash_waitrequest) state_next = S_WAIT_DATA;
         end
         S_WAIT_DATA: begin
            // The outstanding read is always completed; pending commands
            // decide whether the returning word is used or discarded.
            if (restart)    restart_pend_next = 1'b1;
            else if (pause) pause_pend_next   = 1'b1;
            if (tick_ok)    set_overrun       = 1'b1;
            if (flash.flash_readdatavalid) begin
               pause_pend_next   = 1'b0;
               restart_pend_next = 1'b0;
               if (restart_pend_reg || restart) begin
                  addr_next  = restart_addr;
                  state_next = (pause_pend_reg || (pause && !restart)) ? S_PAUSED : S_FETCH;
               end else if (pause_pend_reg || pause) begin
                  state_next = S_PAUSED;
               end else begin
                  load_word  = 1'b1;
                  state_next = S_SAMPLE0;
               end
            end
         end
         S_SAMPLE0: begin
            if (restart) begin
               addr_next       = restart_addr;
               pause_pend_next = 1'b0;
               state_next      = S_FETCH;
            end else if (pause) begin
               pause_pend_next = 1'b1;
            end else if (sample_tick) begin
               emit       = 1'b1;
               emit_byte  = first_sample;
               state_next = S_SAMPLE1;
            end
         end
         S_SAMPLE1: begin
            if (restart) begin
               addr_next       = restart_addr;
               pause_pend_next = 1'b0;
               state_next      = S_FETCH;
            end else if (pause) begin
               pause_pend_next = 1'b1;
            end else if (sample_tick) begin
               emit       = 1'b1;
               emit_byte  = second_sample;
               state_next = S_ADVANCE;
            end
         end
         S_ADVANCE: begin
            if (restart) begin
               addr_next       = restart_addr;
               pause_pend_next = 1'b0;
               state_next      = S_FETCH;
            end else begin
               if (sample_tick && !pause) set_overrun = 1'b1;
               pause_pend_next = 1'b0;
`ifdef PLAYBACK_LOOP_EN
               addr_next  = step_addr;
               state_next = (pause_pend_reg || pause) ? S_PAUSED : S_FETCH;
`else
               if (dir ? (addr_reg == END_ADDR) : (addr_reg == START_ADDR)) begin
                  done_next  = 1'b1;
                  addr_next  = restart_addr;
                  state_next = S_PAUSED;
               end else begin
                  addr_next  = step_addr;
                  state_next = (pause_pend_reg || pause) ? S_PAUSED : S_FETCH;
               end
`endif
            end
         end
         default: state_next = S_PAUSED;
      endcase
   end

   // Output decode from the current state.
   always_comb begin
      flash.flash_read    = (state_reg == S_FETCH);
      flash.flash_address = addr_reg;
      playing             = (state_reg != S_PAUSED);
   end

   // Datapath registers: address, word, pending commands and audio outputs.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         addr_reg         <= START_ADDR;
         word_reg         <= '0;
         word_fwd_reg     <= 1'b1;
         pause_pend_reg   <= 1'b0;
         restart_pend_reg <= 1'b0;
         audio_data       <= 8'h00;
         audio_valid      <= 1'b0;
         overrun          <= 1'b0;
         done             <= 1'b0;
      end else begin
         addr_reg         <= addr_next;
         pause_pend_reg   <= pause_pend_next;
         restart_pend_reg <= restart_pend_next;
         if (load_word)   word_reg     <= flash.flash_readdata;
         if (accept)      word_fwd_reg <= dir;
         audio_valid      <= emit;
         if (emit)        audio_data   <= emit_byte;
         if (set_overrun) overrun      <= 1'b1;
         done             <= done_next;
      end
   end

endmodule

// File: tb/tb_audio_playback_sequencer.sv
// Testbench for audio_playback_sequencer: behavioural flash slave with
// programmable waitrequest / readdatavalid latency, and a scoreboard of
// expected samples checked whenever audio_valid pulses.
module tb_audio_playback_sequencer;

   localparam logic [22:0] START_A = 23'h0;
   localparam logic [22:0] END_A   = 23'h7FFFF;

   logic clk = 1'b0;
   logic reset_n, sample_tick, play, pause, dir, restart;
   logic [7:0] audio_data;
   logic audio_valid, playing, overrun, done;

   audio_playback_sequencer_if #(.ADDR_W(23)) fif ();

   audio_playback_sequencer dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .sample_tick (sample_tick),
      .play        (play),
      .pause       (pause),
      .dir         (dir),
      .restart     (restart),
      .flash       (fif),
      .audio_data  (audio_data),
      .audio_valid (audio_valid),
      .playing     (playing),
      .overrun     (overrun),
      .done        (done)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int rdv_seen = 0;
   int av_cnt = 0;
   int done_cnt = 0;

   // flash model configuration and bookkeeping
   int          ws_cycles = 0;
   int          rdv_delay = 0;
   logic [31:0] next_word = 32'h0;
   logic [22:0] acc_q [$];
   logic [7:0]  exp_q [$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Flash slave: waitrequest for ws_cycles, then data rdv_delay cycles after acceptance.
   initial begin
      int          wcnt;
      int          rdv_left;
      bit          data_pend;
      logic [31:0] data_word;
      logic [22:0] req_addr;
      wcnt = 0; rdv_left = 0; data_pend = 0; data_word = 0; req_addr = 0;
      fif.flash_waitrequest   = 1'b1;
      fif.flash_readdatavalid = 1'b0;
      fif.flash_readdata      = 32'h0;
      forever begin
         @(negedge clk);
         fif.flash_readdatavalid = 1'b0;
         if (data_pend) begin
            if (rdv_left == 0) begin
               fif.flash_readdatavalid = 1'b1;
               fif.flash_readdata      = data_word;
               data_pend               = 0;
            end else begin
               rdv_left--;
            end
         end
         if (fif.flash_read) begin
            if (wcnt == 0) req_addr = fif.flash_address;
            else check("addr_stable", 32'(fif.flash_address), 32'(req_addr));
            if (wcnt < ws_cycles) begin
               fif.flash_waitrequest = 1'b1;
               wcnt++;
            end else begin
               fif.flash_waitrequest = 1'b0;
               acc_q.push_back(fif.flash_address);
               data_pend = 1;
               rdv_left  = rdv_delay;
               data_word = next_word;
               wcnt      = 0;
            end
         end else begin
            fif.flash_waitrequest = 1'b1;
            wcnt = 0;
         end
      end
   end

   // Output monitor, sampled 2 time units after each rising edge.
   initial begin
      logic [7:0] e;
      forever begin
         @(posedge clk);
         #2;
         if (fif.flash_readdatavalid) rdv_seen++;
         if (done) done_cnt++;
         if (audio_valid) begin
            av_cnt++;
            check("av_latency", 32'(sample_tick), 32'd1);
            check("av_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("audio_data", 32'(audio_data), 32'(e));
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic drive(input bit t, input bit pl, input bit pa, input bit rs);
      @(negedge clk);
      sample_tick = t; play = pl; pause = pa; restart = rs;
      @(negedge clk);
      sample_tick = 0; play = 0; pause = 0; restart = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_read"},   32'(fif.flash_read), 32'd0);
      check({tag, "_addr"},   32'(fif.flash_address), 32'(START_A));
      check({tag, "_data"},   32'(audio_data), 32'd0);
      check({tag, "_valid"},  32'(audio_valid), 32'd0);
      check({tag, "_overrun"},32'(overrun), 32'd0);
      check({tag, "_done"},   32'(done), 32'd0);
      check({tag, "_playing"},32'(playing), 32'd0);
   endtask

   task automatic wait_rdv(input string tag);
      int start;
      int k;
      start = rdv_seen;
      k = 0;
      while (rdv_seen == start && k < 200) begin
         @(negedge clk);
         k++;
      end
      check(tag, 32'(rdv_seen != start), 32'd1);
   endtask

   task automatic expect_addr(input string tag, input logic [22:0] exp);
      logic [31:0] got;
      if (acc_q.size() > 0) got = 32'(acc_q.pop_front());
      else got = 32'hFFFF_FFFF;
      check(tag, got, 32'(exp));
   endtask

   initial begin
      int base;
      int dbase;
      reset_n = 0; sample_tick = 0; play = 0; pause = 0; dir = 1; restart = 0;
      repeat (3) @(negedge clk);
      check_idle("rst");
      reset_n = 1;

      // basic forward fetch with two waitrequest cycles
      base = av_cnt;
      ws_cycles = 2; rdv_delay = 0; next_word = 32'hA1B2C3D4;
      drive(0, 1, 0, 0);
      check("t1_playing", 32'(playing), 32'd1);
      wait_rdv("t1_rdv0");
      expect_addr("t1_addr0", START_A);
      exp_q.push_back(8'hC3);
      drive(1, 0, 0, 0);
      repeat (3) @(negedge clk);
      next_word = 32'h01020304;
      exp_q.push_back(8'hA1);
      drive(1, 0, 0, 0);
      wait_rdv("t1_rdv1");
      expect_addr("t1_addr1", 23'd1);
      check("t1_flash_addr", 32'(fif.flash_address), 32'd1);
      check("t1_av_cnt", 32'(av_cnt - base), 32'd2);
      check("t1_drain", 32'(exp_q.size()), 32'd0);

      // backward order from END_ADDR
      do_reset();
      base = av_cnt;
      ws_cycles = 0; dir = 0; next_word = 32'h11223344;
      drive(0, 0, 0, 1);
      check("t2_restart_addr", 32'(fif.flash_address), 32'(END_A));
      drive(0, 1, 0, 0);
      wait_rdv("t2_rdv0");
      expect_addr("t2_addr0", END_A);
      next_word = 32'h0;
      exp_q.push_back(8'h11);
      drive(1, 0, 0, 0);
      exp_q.push_back(8'h33);
      drive(1, 0, 0, 0);
      wait_rdv("t2_rdv1");
      expect_addr("t2_addr1", END_A - 23'd1);
      check("t2_av_cnt", 32'(av_cnt - base), 32'd2);
      check("t2_drain", 32'(exp_q.size()), 32'd0);

      // forward wrap at END_ADDR
      do_reset();
      base = av_cnt;
      dir = 0;
      drive(0, 0, 0, 1);
      dir = 1; next_word = 32'h55667788;
      drive(0, 1, 0, 0);
      wait_rdv("t3_rdv0");
      expect_addr("t3_addr0", END_A);
      next_word = 32'h0;
      exp_q.push_back(8'h77);
      drive(1, 0, 0, 0);
      dbase = done_cnt;
      exp_q.push_back(8'h55);
      drive(1, 0, 0, 0);
      repeat (4) @(negedge clk);
`ifdef PLAYBACK_LOOP_EN
      wait_rdv("t3_rdv1");
      expect_addr("t3_wrap_addr", START_A);
      check("t3_playing", 32'(playing), 32'd1);
      check("t3_done_cnt", 32'(done_cnt - dbase), 32'd0);
`else
      check("t3_done_cnt", 32'(done_cnt - dbase), 32'd1);
      check("t3_playing", 32'(playing), 32'd0);
      check("t3_reload", 32'(fif.flash_address), 32'(START_A));
      drive(1, 0, 0, 0);
      drive(1, 0, 0, 0);
      check("t3_overrun", 32'(overrun), 32'd0);
`endif
      check("t3_av_cnt", 32'(av_cnt - base), 32'd2);
      check("t3_drain", 32'(exp_q.size()), 32'd0);

      // pause (with a coincident tick) while read data is delayed
      do_reset();
      base = av_cnt;
      dir = 1; ws_cycles = 0; rdv_delay = 5; next_word = 32'hCAFEF00D;
      drive(0, 1, 0, 0);
      drive(1, 0, 1, 0);
      check("t4_read_low", 32'(fif.flash_read), 32'd0);
      wait_rdv("t4_rdv0");
      repeat (3) @(negedge clk);
      check("t4_playing", 32'(playing), 32'd0);
      check("t4_overrun", 32'(overrun), 32'd0);
      check("t4_av_cnt", 32'(av_cnt - base), 32'd0);
      expect_addr("t4_addr0", START_A);
      rdv_delay = 0; next_word = 32'h0A0B0C0D;
      drive(0, 1, 0, 0);
      wait_rdv("t4_rdv1");
      expect_addr("t4_refetch", START_A);
      exp_q.push_back(8'h0C);
      drive(1, 0, 0, 0);
      check("t4_drain", 32'(exp_q.size()), 32'd0);

      // overrun while waitrequest is held
      do_reset();
      base = av_cnt;
      ws_cycles = 20; next_word = 32'h12345678;
      drive(0, 1, 0, 0);
      drive(1, 0, 0, 0);
      check("t5_overrun", 32'(overrun), 32'd1);
      check("t5_data_hold", 32'(audio_data), 32'd0);
      check("t5_av_cnt", 32'(av_cnt - base), 32'd0);
      repeat (3) @(negedge clk);
      drive(1, 0, 0, 0);
      wait_rdv("t5_rdv0");
      expect_addr("t5_addr0", START_A);
      check("t5_overrun_hold", 32'(overrun), 32'd1);
      exp_q.push_back(8'h56);
      drive(1, 0, 0, 0);
      check("t5_sticky", 32'(overrun), 32'd1);
      check("t5_drain", 32'(exp_q.size()), 32'd0);

      // reset in the middle of an outstanding read
      do_reset();
      ws_cycles = 2; rdv_delay = 0; next_word = 32'hDEADBEEF;
      drive(0, 1, 0, 0);
      drive(1, 0, 0, 0);
      wait_rdv("t6_rdv0");
      exp_q.push_back(8'hBE);
      drive(1, 0, 0, 0);
      rdv_delay = 6; next_word = 32'h0;
      exp_q.push_back(8'hDE);
      drive(1, 0, 0, 0);
      check("t6_pre_data", 32'(audio_data), 32'hDE);
      repeat (4) @(negedge clk);
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      check_idle("t6_rst");
      reset_n = 1'b1;
      base = av_cnt;
      repeat (8) @(negedge clk);
      check("t6_late_rdv", 32'(av_cnt - base), 32'd0);
      check("t6_playing", 32'(playing), 32'd0);
      check("t6_read", 32'(fif.flash_read), 32'd0);
      expect_addr("t6_addr0", START_A);
      expect_addr("t6_addr1", 23'd1);
      rdv_delay = 0;

      // priority: restart + pause + play together, then restart mid-word
      do_reset();
      base = av_cnt;
      ws_cycles = 0; dir = 0;
      drive(0, 1, 1, 1);
      check("t7_addr", 32'(fif.flash_address), 32'(END_A));
      check("t7_playing", 32'(playing), 32'd0);
      check("t7_read", 32'(fif.flash_read), 32'd0);
      next_word = 32'h99AABBCC;
      drive(0, 1, 0, 0);
      wait_rdv("t7_rdv0");
      expect_addr("t7_addr0", END_A);
      next_word = 32'h0;
      exp_q.push_back(8'h99);
      drive(1, 0, 0, 0);
      dir = 1;
      drive(0, 0, 0, 1);
      wait_rdv("t7_rdv1");
      expect_addr("t7_restart_addr", START_A);
      check("t7_av_cnt", 32'(av_cnt - base), 32'd1);
      check("t7_drain", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/audio_playback_sequencer.md
Name: audio_playback_sequencer

Overview:
- Sequences audio playback out of on-board flash through an Avalon-MM read master, one 32-bit word at a time.
- Each word holds two 16-bit samples. The block emits one 8-bit sample per sample_tick.
- sample_tick comes from the rate divider whose terminal count is set by the speed controller. This block owns play, pause, direction and restart.
- Sits between the keyboard command decoder and the flash controller / audio output path.

Parameters:
- ADDR_W, 23, flash word-address width.
- END_ADDR, 23'h7FFFF, last word address of the audio image.
- START_ADDR, 23'h0, first word address of the audio image.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous active-low reset.
- sample_tick  in  1  one-cycle pulse; consume one sample.
- play  in  1  level/pulse; start or resume playback.
- pause  in  1  level/pulse; stop at the next word boundary.
- dir  in  1  1 = forward, 0 = backward; sampled at each word fetch.
- restart  in  1  pulse; jump to START_ADDR (forward) or END_ADDR (backward).
- flash_read  out  1  Avalon read strobe.
- flash_address  out  ADDR_W  word address.
- flash_waitrequest  in  1  Avalon waitrequest.
- flash_readdata  in  32  read data.
- flash_readdatavalid  in  1  read data valid.
- audio_data  out  8  current sample, signed.
- audio_valid  out  1  one-cycle pulse; audio_data updated.
- playing  out  1  high in every state except PAUSED.
- overrun  out  1  sticky; a tick arrived with no sample ready.
- done  out  1  one-cycle pulse at end of image (non-loop build only).

Behaviour:
- Reset (reset_n low at a clk edge):
  - State = PAUSED; flash_address = START_ADDR; word register = 0.
  - flash_read = 0, audio_data = 0, audio_valid = 0, overrun = 0, done = 0, playing = 0.
- Command priority, per cycle: restart > pause > play.
- Ticks: a tick in the same cycle as pause or restart is ignored and does not set overrun.
- PAUSED:
  - Ticks are ignored.
  - play -> FETCH.
  - restart loads the address and stays PAUSED.
- FETCH:
  - Assert flash_read with a stable flash_address until flash_waitrequest is sampled low, then go to WAIT_DATA.
  - flash_read drops the cycle after acceptance.
- WAIT_DATA:
  - On flash_readdatavalid, latch flash_readdata and go to SAMPLE0.
  - restart or pause here is recorded in a pending flag. The state still waits for readdatavalid, discards the word, then applies the pending action (restart -> FETCH at the new address; pause -> PAUSED).
  - An outstanding read is never abandoned.
- SAMPLE0:
  - Forward: on sample_tick, audio_data = word[15:8].
  - Backward: on sample_tick, audio_data = word[31:24].
  - audio_valid is high the cycle after the tick, with audio_data valid in that same cycle. Latency is 1 clk from tick.
  - Then go to SAMPLE1.
- SAMPLE1:
  - On sample_tick, emit the other sample: forward word[31:24], backward word[15:8].
  - Then go to ADVANCE.
- ADVANCE (one cycle):
  - Forward: address + 1; END_ADDR wraps to START_ADDR.
  - Backward: address - 1; START_ADDR wraps to END_ADDR.
  - A pause seen since the last fetch -> PAUSED; otherwise -> FETCH.
- Direction change: takes effect at the next ADVANCE. The current word finishes in its old order.
- Overrun:
  - A sample_tick in FETCH, WAIT_DATA or ADVANCE sets overrun, which stays set until reset.
  - That tick produces no audio_valid, and audio_data holds its value.
- Restart in SAMPLE0/1/ADVANCE: load the address and go to FETCH next cycle. The remaining sample of the current word is dropped.
- Reset mid-read: state returns to PAUSED.
  - A readdatavalid arriving after reset is ignored, because it is only honoured in WAIT_DATA.
  - The flash controller must be reset by the same reset_n.
- Address arithmetic is ADDR_W bits wide, with explicit compares against END_ADDR/START_ADDR. No reliance on natural wrap.

Optional Feature:
- Macro: PLAYBACK_LOOP_EN.
- Defined: wrap-around as described above; done is tied 0.
- Undefined:
  - On ADVANCE from END_ADDR (forward) or START_ADDR (backward), pulse done for 1 cycle.
  - Reload the address to START_ADDR (forward) or END_ADDR (backward).
  - Go to PAUSED; play is required to continue.

Test Plan:
- Basic fetch: reset, play, flash returns 32'hA1B2C3D4 after 2 waitrequest cycles; tick, then tick later -> audio_data 8'hC3 then 8'hA1, each audio_valid pulse exactly 1 cycle after its tick, flash_address then 1.
- Backward order: dir = 0, restart, play, word 32'h11223344 -> first access at END_ADDR, samples 8'h11 then 8'h33, next address END_ADDR-1.
- Forward wrap: address END_ADDR, forward, two ticks -> loop build fetches START_ADDR next; non-loop build pulses done once, playing = 0, further ticks produce no audio_valid.
- Pause during WAIT_DATA: pause while readdatavalid is delayed 5 cycles -> flash_read stays low, word discarded, state PAUSED, no audio_valid, overrun = 0.
- Overrun: sample_tick asserted while waitrequest is held high -> overrun = 1 and stays 1; audio_data unchanged.
- Reset and priority: reset_n low mid-read -> all outputs 0 next cycle, late readdatavalid ignored; restart + pause + play in one cycle -> restart address loaded, state PAUSED.
